// File: rtl/mult30_reduction_feeder.sv
// 30x30 three-stage pipelined multiplier feeding the 60-bit modular reduction stage; 3-cycle product
// latency. Never stalls. Sel/tag ride a RED_LAT delay line so write-back sees tag aligned with the result.
module mult30_reduction_feeder #(
  parameter int TAG_W   = 12,
  parameter int RED_LAT = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [29:0]      a,
  input  logic [29:0]      b,
  input  logic             in_sel,
  input  logic [TAG_W-1:0] in_tag,
  output logic [59:0]      prod,
  output logic             prod_valid,
  output logic             red_sel,
  output logic             res_valid,
  output logic [TAG_W-1:0] res_tag,
  output logic             busy,
  output logic [2:0]       inflight
);

  // M1 operand registers
  logic             v1_q, v1_d;
  logic [29:0]      a1_q, a1_d, b1_q, b1_d;
  logic             sel1_q, sel1_d;
  logic [TAG_W-1:0] tag1_q, tag1_d;

  // M2 partial products
  logic             v2_q, v2_d;
  logic [29:0]      pp_hh_q, pp_hh_d, pp_hl_q, pp_hl_d, pp_lh_q, pp_lh_d, pp_ll_q, pp_ll_d;
  logic             sel2_q, sel2_d;
  logic [TAG_W-1:0] tag2_q, tag2_d;

  // Index 0 of the delay line is the M3 stage itself; index k is k cycles after prod.
  logic [59:0]      prod_q, prod_d;
  logic [RED_LAT:0] dv_q, dv_d;
  logic [RED_LAT:0] dsel_q, dsel_d;
  logic [TAG_W-1:0] dtag_q [0:RED_LAT];
  logic [TAG_W-1:0] dtag_d [0:RED_LAT];

  logic [30:0]      mid_sum;
  logic [2:0]       cnt;

  always_comb begin
    a1_d    = a1_q;
    b1_d    = b1_q;
    sel1_d  = sel1_q;
    tag1_d  = tag1_q;
    v1_d    = in_valid;
    if (in_valid) begin
      a1_d   = a;
      b1_d   = b;
      sel1_d = in_sel;
      tag1_d = in_tag;
    end

    pp_hh_d = pp_hh_q;
    pp_hl_d = pp_hl_q;
    pp_lh_d = pp_lh_q;
    pp_ll_d = pp_ll_q;
    sel2_d  = sel2_q;
    tag2_d  = tag2_q;
    v2_d    = v1_q;
    if (v1_q) begin
      pp_hh_d = {15'd0, a1_q[29:15]} * {15'd0, b1_q[29:15]};
      pp_hl_d = {15'd0, a1_q[29:15]} * {15'd0, b1_q[14:0]};
      pp_lh_d = {15'd0, a1_q[14:0]}  * {15'd0, b1_q[29:15]};
      pp_ll_d = {15'd0, a1_q[14:0]}  * {15'd0, b1_q[14:0]};
      sel2_d  = sel1_q;
      tag2_d  = tag1_q;
    end

    // Cross terms can carry into bit 30, so the middle sum is kept at 31 bits.
    mid_sum = {1'b0, pp_hl_q} + {1'b0, pp_lh_q};
    prod_d  = prod_q;
    dv_d    = dv_q;
    dsel_d  = dsel_q;
    dtag_d  = dtag_q;
    dv_d[0] = v2_q;
    if (v2_q) begin
      prod_d    = {pp_hh_q, 30'd0} + {14'd0, mid_sum, 15'd0} + {30'd0, pp_ll_q};
      dsel_d[0] = sel2_q;
      dtag_d[0] = tag2_q;
    end

    for (int i = 1; i <= RED_LAT; i++) begin
      dv_d[i] = dv_q[i-1];
      if (dv_q[i-1]) begin
        dsel_d[i] = dsel_q[i-1];
        dtag_d[i] = dtag_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q    <= 1'b0;
      a1_q    <= '0;
      b1_q    <= '0;
      sel1_q  <= 1'b0;
      tag1_q  <= '0;
      v2_q    <= 1'b0;
      pp_hh_q <= '0;
      pp_hl_q <= '0;
      pp_lh_q <= '0;
      pp_ll_q <= '0;
      sel2_q  <= 1'b0;
      tag2_q  <= '0;
      prod_q  <= '0;
      dv_q    <= '0;
      dsel_q  <= '0;
      for (int i = 0; i <= RED_LAT; i++) begin
        dtag_q[i] <= '0;
      end
    end else begin
      v1_q    <= v1_d;
      a1_q    <= a1_d;
      b1_q    <= b1_d;
      sel1_q  <= sel1_d;
      tag1_q  <= tag1_d;
      v2_q    <= v2_d;
      pp_hh_q <= pp_hh_d;
      pp_hl_q <= pp_hl_d;
      pp_lh_q <= pp_lh_d;
      pp_ll_q <= pp_ll_d;
      sel2_q  <= sel2_d;
      tag2_q  <= tag2_d;
      prod_q  <= prod_d;
      dv_q    <= dv_d;
      dsel_q  <= dsel_d;
      dtag_q  <= dtag_d;
    end
  end

  // Operands count as in flight until their res_valid cycle, so the final delay stage is excluded.
  always_comb begin
    cnt = {2'd0, v1_q} + {2'd0, v2_q};
    for (int i = 0; i < RED_LAT; i++) begin
      cnt = cnt + {2'd0, dv_q[i]};
    end
  end

  // Data registers hold when their stage is empty, so red_sel keeps its last value for free.
  assign red_sel    = dsel_q[RED_LAT-1];
  assign prod       = prod_q;
  assign prod_valid = dv_q[0];
  assign res_valid  = dv_q[RED_LAT];
  assign res_tag    = dtag_q[RED_LAT];
  assign inflight   = cnt;
  assign busy       = (cnt != 3'd0);

endmodule

// File: tb/tb_mult30_reduction_feeder.sv
// Bench for mult30_reduction_feeder: RED_LAT=3 and RED_LAT=4 instances share stimulus and are
// compared cycle by cycle against a history-based reference model plus a behavioural reduction.
module tb_mult30_reduction_feeder;

  localparam logic [63:0] QS = 64'd1068564481;
  localparam logic [63:0] QL = 64'd1073479681;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [29:0] a = '0, b = '0;
  logic        in_sel = 1'b0;
  logic [11:0] in_tag = '0;

  logic [59:0] prod0, prod1;
  logic        pv0, pv1, rsel0, rsel1, rv0, rv1, busy0, busy1;
  logic [11:0] rtag0, rtag1;
  logic [2:0]  inf0, inf1;

  int total = 0;
  int bad = 0;
  int t = 0;
  int epoch = 0;
  int max_inf [2] = '{0, 0};

  logic        hv [0:1023];
  logic [29:0] ha [0:1023];
  logic [29:0] hb [0:1023];
  logic        hs [0:1023];
  logic [11:0] ht [0:1023];
  logic [59:0] obs_prod [2][0:1023];
  logic        obs_rsel [2][0:1023];

  always #5 clk = ~clk;

  mult30_reduction_feeder #(.TAG_W(12), .RED_LAT(3)) u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b), .in_sel(in_sel), .in_tag(in_tag),
    .prod(prod0), .prod_valid(pv0), .red_sel(rsel0), .res_valid(rv0), .res_tag(rtag0),
    .busy(busy0), .inflight(inf0));

  mult30_reduction_feeder #(.TAG_W(12), .RED_LAT(4)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b), .in_sel(in_sel), .in_tag(in_tag),
    .prod(prod1), .prod_valid(pv1), .red_sel(rsel1), .res_valid(rv1), .res_tag(rtag1),
    .busy(busy1), .inflight(inf1));

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s t=%0d got=%0h exp=%0h", nm, t, got, exp);
    end
  endtask

  function automatic logic was_valid(input int k);
    if (k < 0 || k < epoch) return 1'b0;
    return hv[k];
  endfunction

  function automatic int last_valid(input int k);
    for (int i = k; i >= 0 && i >= epoch; i--) begin
      if (hv[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [63:0] prod_of(input int j);
    if (j < 0) return 64'd0;
    return {34'd0, ha[j]} * {34'd0, hb[j]};
  endfunction

  // Expected outputs of the DUT with reduction latency lat during cycle t, from input history only.
  task automatic check_dut(input int d, input int lat, input logic [59:0] p, input logic pv,
                           input logic rv, input logic [11:0] rt, input logic rs,
                           input logic [2:0] inf, input logic bsy);
    int jp, jr, js, n;
    logic [63:0] q_obs, q_exp;
    obs_prod[d][t] = p;
    obs_rsel[d][t] = rs;
    jp = last_valid(t - 3);
    jr = last_valid(t - 3 - lat);
    js = last_valid(t - 2 - lat);
    n = 0;
    for (int k = t - 2 - lat; k <= t - 1; k++) n += int'(was_valid(k));
    if (int'(inf) > max_inf[d]) max_inf[d] = int'(inf);
    chk($sformatf("d%0d_prod_valid", d), {63'd0, pv}, {63'd0, was_valid(t - 3)});
    chk($sformatf("d%0d_prod", d), {4'd0, p}, prod_of(jp));
    chk($sformatf("d%0d_res_valid", d), {63'd0, rv}, {63'd0, was_valid(t - 3 - lat)});
    chk($sformatf("d%0d_res_tag", d), {52'd0, rt}, (jr < 0) ? 64'd0 : {52'd0, ht[jr]});
    chk($sformatf("d%0d_red_sel", d), {63'd0, rs}, (js < 0) ? 64'd0 : {63'd0, hs[js]});
    chk($sformatf("d%0d_inflight", d), {61'd0, inf}, 64'(n));
    chk($sformatf("d%0d_busy", d), {63'd0, bsy}, {63'd0, (n != 0)});
    if (was_valid(t - 3 - lat)) begin
      // Reduction samples prod lat cycles back and modulus_sel one cycle back.
      q_obs = obs_rsel[d][t - 1] ? QL : QS;
      q_exp = hs[jr] ? QL : QS;
      chk($sformatf("d%0d_reduced", d), {4'd0, obs_prod[d][t - lat]} % q_obs, prod_of(jr) % q_exp);
    end
  endtask

  task automatic step(input logic v, input logic [29:0] aa, input logic [29:0] bb,
                      input logic s, input logic [11:0] tg);
    in_valid = v;
    a = aa;
    b = bb;
    in_sel = s;
    in_tag = tg;
    hv[t] = v;
    ha[t] = aa;
    hb[t] = bb;
    hs[t] = s;
    ht[t] = tg;
    check_dut(0, 3, prod0, pv0, rv0, rtag0, rsel0, inf0, busy0);
    check_dut(1, 4, prod1, pv1, rv1, rtag1, rsel1, inf1, busy1);
    @(posedge clk);
    #1;
    t++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 30'd0, 30'd0, 1'b0, 12'd0);
  endtask

  task automatic check_all_zero(input string nm);
    chk({nm, "_d0"}, {prod0, pv0, rv0, rsel0, rtag0, inf0, busy0}, 64'd0);
    chk({nm, "_d1"}, {prod1, pv1, rv1, rsel1, rtag1, inf1, busy1}, 64'd0);
  endtask

  function automatic logic [29:0] r30();
    return 30'($urandom);
  endfunction

  initial begin
    int pat [7];
    pat = '{1, 0, 0, 1, 1, 0, 1};

    #1;
    check_all_zero("reset_init");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // single product
    step(1'b1, 30'd3, 30'd5, 1'b0, 12'h00A);
    idle(9);

    // maximum operands under both moduli
    step(1'b1, 30'h3FFFFFFF, 30'h3FFFFFFF, 1'b0, 12'h011);
    step(1'b1, 30'h3FFFFFFF, 30'h3FFFFFFF, 1'b1, 12'h012);
    idle(1);
    chk("max_prod", {4'd0, prod0}, 64'h0FFFFFFF80000001);
    idle(8);

    // streaming
    for (int i = 0; i < 64; i++) step(1'b1, r30(), r30(), 1'($urandom), 12'(i));
    idle(9);
    chk("peak_inflight_d0", 64'(max_inf[0]), 64'd5);
    chk("peak_inflight_d1", 64'(max_inf[1]), 64'd6);

    // bubbles
    for (int i = 0; i < 7; i++) step(1'(pat[i]), r30(), r30(), 1'($urandom), 12'(12'h100 + i));
    idle(9);

    // reset while four operands are in flight
    for (int i = 0; i < 4; i++) step(1'b1, r30(), r30(), 1'($urandom), 12'(12'h200 + i));
    in_valid = 1'b0;
    hv[t] = 1'b0;
    check_dut(0, 3, prod0, pv0, rv0, rtag0, rsel0, inf0, busy0);
    check_dut(1, 4, prod1, pv1, rv1, rtag1, rsel1, inf1, busy1);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("reset_async");
    epoch = t + 1;
    @(posedge clk);
    #1;
    t++;
    rst_n = 1'b1;
    step(1'b1, r30(), r30(), 1'b1, 12'h2AA);
    idle(9);

    // alternating sel, back to back
    for (int i = 0; i < 8; i++) step(1'b1, r30(), r30(), 1'(i % 2), 12'(12'h300 + i));
    idle(9);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
